morse_sequencer: RTL and testbench
==================================

# morse_sequencer

Plays a queue of Morse letters on the board LED. It accepts 3-bit letter codes (A–H) through a valid/ready handshake into a small FIFO and looks up each letter's 12-bit on/off pattern. It shifts the pattern out MSB-first at one symbol per tick and inserts a fixed silent gap between letters. It replaces manual per-letter KEY loading and sits between the switch/key front end and LEDR[0].

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per symbol (0.5 s at 50 MHz); must be ≥ 2.
- `PAT_W`, default 12: pattern length in symbols.
- `GAP_TICKS`, default 3: silent symbols between letters; must be ≥ 1.
- `FIFO_DEPTH`, default 4: queued letters; must be a power of 2.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `in_valid`  in  1  letter code offered.
- `in_ready`  out  1  FIFO can accept; equals `!full && !abort`.
- `in_code`  in  3  letter code, 0=A … 7=H.
- `abort`  in  1  synchronous flush of the FIFO and the current letter.
- `led`  out  1  Morse output.
- `busy`  out  1  high when state ≠ IDLE or the FIFO is non-empty.
- `letter_done`  out  1  one-cycle pulse when a letter's gap completes.

## Operation
- Reset values:
  - state = IDLE, FIFO empty, shift register 0.
  - `led`=0, `busy`=0, `letter_done`=0, `in_ready`=1 in the cycle after reset deasserts.
- Priority: reset > abort > normal operation.
- Handshake: a push occurs on an edge where `in_valid && in_ready`. There is no bypass, so a push is refused when the FIFO is full even if a pop happens in the same cycle.
- Pattern ROM maps codes A–H to:
  - A=010111000000, B=011101010100, C=011101011101, D=011101010000
  - E=010000000000, F=010101110100, G=011101110100, H=010101010000
- States:
  - **IDLE**: `led`=0. If the FIFO is non-empty, go to LOAD.
  - **LOAD**: exactly one cycle.
    - Pop the FIFO; shift register ← pattern.
    - Symbol count ← PAT_W; tick counter ← TICK_DIV−1.
    - Go to SHIFT.
  - **SHIFT**: `led` = shift register MSB.
    - On each tick: shift left by 1 (zero fill) and decrement the count.
    - When the count reaches 0: gap count ← GAP_TICKS and go to GAP.
  - **GAP**: `led`=0. On each tick, decrement the gap count.
    - When it reaches 0: go to IDLE and pulse `letter_done` in the first IDLE cycle.
- Tick: asserted when the tick counter = 0; the counter then reloads TICK_DIV−1, otherwise it decrements. It counts only in SHIFT and GAP and is reloaded in LOAD.
- Tick counter width is $clog2(TICK_DIV). The symbol counter is sized for PAT_W and the gap counter for GAP_TICKS; none of them wrap.
- Abort: the next state is IDLE and the FIFO is emptied. `led`=0 from the next cycle, and no `letter_done` pulse is generated. An `in_valid` in an abort cycle is dropped.
- Reset mid-letter has the same effect as abort, plus all registers return to their reset values.

## Timing
- Handshake on edge t into an empty FIFO while IDLE:
  - LOAD during cycle t+1.
  - SHIFT from t+2, with `led` = pattern bit 11 starting at t+2.
- Each symbol is held exactly TICK_DIV cycles.
- SHIFT lasts PAT_W·TICK_DIV cycles and GAP lasts GAP_TICKS·TICK_DIV cycles.
- Back-to-back letters: each GAP→IDLE→LOAD costs 2 extra cycles. The next letter's first symbol starts 2 cycles after the previous gap ends.
- `in_ready` is combinational from the FIFO count and `abort`. `led`, `busy` and `letter_done` are registered or derived from state only, with no combinational path from the inputs.

## Structure
- Shared package `morse_pkg`:
  - `letter_code_t` (3-bit) and `PAT_W_DEFAULT`.
  - The 8 pattern constants and the `seq_state_t` enum {IDLE, LOAD, SHIFT, GAP}.
- Sub-module `morse_fifo`: a synchronous FIFO parameterised by depth and width, with push/pop, full/empty and a synchronous flush input driven by abort.
- The pattern ROM, FSM and counters stay in the top module.

## Test plan
All scenarios use TICK_DIV=4, GAP_TICKS=2, FIFO_DEPTH=4.
1. **Single letter.** Push A at edge t.
   - `led` = 0,1,0,1,1,1,0,0,0,0,0,0, each symbol held 4 cycles, starting at t+2.
   - Then 8 cycles of `led`=0, then a `letter_done` pulse; `busy` falls in the same cycle.
2. **Back-to-back letters.** Push E then H in consecutive cycles.
   - H's first symbol starts 2 cycles after E's gap ends.
   - Exactly two `letter_done` pulses are produced.
3. **Full FIFO.** Push 6 codes while the first is playing.
   - `in_ready`=0 once 4 codes are queued.
   - The refused code is never played.
   - A push attempted in the cycle of a pop while full is refused.
4. **Abort mid-SHIFT.** Assert abort during C's 5th symbol with 2 codes queued.
   - `led`=0 the next cycle; state returns to IDLE; FIFO empty; `busy`=0; no `letter_done`.
5. **Reset mid-GAP.** Assert reset during a gap with `in_valid` high.
   - The cycle after deassertion shows all outputs at reset values and `in_ready`=1.
   - The code offered during reset is not stored.
6. **Abort with valid.** Assert abort and `in_valid` (code G) in the same cycle while IDLE.
   - `in_ready`=0 in that cycle; G is never played.

Source files
------------

// File: rtl/morse_pkg.sv
// ----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse letter sequencer.
//   letter_code_t  3-bit letter code, 0=A ... 7=H
//   PAT_W_DEFAULT  symbols per letter pattern
//   PAT_A..PAT_H   on/off symbol patterns, MSB played first
//   seq_state_t    sequencer FSM states
//   pattern_of()   pattern ROM lookup
// ----------------------------------------------------------------------------
package morse_pkg;

  localparam int PAT_W_DEFAULT = 12;

  typedef logic [2:0]               letter_code_t;
  typedef logic [PAT_W_DEFAULT-1:0] pattern_t;

  localparam pattern_t PAT_A = 12'b010111000000;
  localparam pattern_t PAT_B = 12'b011101010100;
  localparam pattern_t PAT_C = 12'b011101011101;
  localparam pattern_t PAT_D = 12'b011101010000;
  localparam pattern_t PAT_E = 12'b010000000000;
  localparam pattern_t PAT_F = 12'b010101110100;
  localparam pattern_t PAT_G = 12'b011101110100;
  localparam pattern_t PAT_H = 12'b010101010000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  function automatic pattern_t pattern_of(letter_code_t code);
    pattern_t pat;
    pat = PAT_A;
    case (code)
      3'd0: pat = PAT_A;
      3'd1: pat = PAT_B;
      3'd2: pat = PAT_C;
      3'd3: pat = PAT_D;
      3'd4: pat = PAT_E;
      3'd5: pat = PAT_F;
      3'd6: pat = PAT_G;
      3'd7: pat = PAT_H;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// ----------------------------------------------------------------------------
// morse_fifo
// Small synchronous FIFO with a synchronous flush; DEPTH must be a power of 2.
// Ports:
//   i_clock    clock
//   i_reset    synchronous active-high reset (empties the FIFO)
//   i_flush    synchronous flush, same effect as reset on the pointers
//   i_push     write i_wr_data (ignored when full)
//   i_pop      drop the head entry (ignored when empty)
//   i_wr_data  data to write
//   o_rd_data  head entry (valid when !o_empty)
//   o_full     DEPTH entries stored
//   o_empty    no entries stored
// ----------------------------------------------------------------------------
module morse_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers define
  // which entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge i_clock) begin
    if (w_do_push && !i_reset && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/morse_sequencer.sv
// ----------------------------------------------------------------------------
// morse_sequencer
// Queues 3-bit letter codes (A-H) and plays each letter's 12-symbol on/off
// pattern on a single LED, one symbol per tick, followed by a silent gap.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   in_valid     letter code offered
//   in_ready     FIFO can accept (!full && !abort)
//   in_code      letter code, 0=A ... 7=H
//   abort        synchronous flush of the queue and the current letter
//   led          Morse output
//   busy         a letter is in progress or queued
//   letter_done  one-cycle pulse after a letter's gap completes
// ----------------------------------------------------------------------------
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int PAT_W      = PAT_W_DEFAULT,
  parameter int GAP_TICKS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic       abort,
  output logic       led,
  output logic       busy,
  output logic       letter_done
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SYM_W  = $clog2(PAT_W + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [PAT_W-1:0]  r_shift;
  logic [SYM_W-1:0]  r_sym_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_letter_done;

  letter_code_t      w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_tick;
  logic              w_last_symbol;
  logic              w_last_gap;

  assign in_ready      = !w_full && !abort;
  assign w_push        = in_valid && in_ready;
  assign w_pop         = (r_state == LOAD);
  assign w_tick        = (r_tick_cnt == '0);
  assign w_last_symbol = w_tick && (r_sym_cnt == SYM_W'(1));
  assign w_last_gap    = w_tick && (r_gap_cnt == GAP_W'(1));
  assign letter_done   = r_letter_done;

  morse_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(letter_code_t))
  ) u_fifo (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_flush   (abort),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (in_code),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and state-derived outputs; nothing here depends on the
  // handshake inputs except abort's redirect of the next state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a latch behind.
    w_next_state = r_state;
    led          = 1'b0;
    busy         = (r_state != IDLE) || !w_empty;
    case (r_state)
      IDLE:  if (!w_empty) w_next_state = LOAD;
      LOAD:  w_next_state = SHIFT;
      SHIFT: begin
        led = r_shift[PAT_W-1];
        if (w_last_symbol) w_next_state = GAP;
      end
      GAP:   if (w_last_gap) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (abort) w_next_state = IDLE;
  end

  // Datapath: pattern shifter and the tick/symbol/gap counters. The tick
  // counter runs continuously through SHIFT into GAP so both phases see
  // whole TICK_DIV-cycle symbols.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift       <= '0;
      r_sym_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_tick_cnt    <= '0;
      r_letter_done <= 1'b0;
    end else begin
      r_letter_done <= (r_state == GAP) && w_last_gap && !abort;
      if (abort) begin
        r_shift <= '0;
      end else begin
        case (r_state)
          LOAD: begin
            r_shift    <= PAT_W'(pattern_of(w_head));
            r_sym_cnt  <= SYM_W'(PAT_W);
            r_tick_cnt <= TICK_RELOAD;
          end
          SHIFT: begin
            r_tick_cnt <= w_tick ? TICK_RELOAD : r_tick_cnt - TICK_W'(1);
            if (w_tick) begin
              r_shift   <= {r_shift[PAT_W-2:0], 1'b0};
              r_sym_cnt <= r_sym_cnt - SYM_W'(1);
            end
            if (w_last_symbol) r_gap_cnt <= GAP_W'(GAP_TICKS);
          end
          GAP: begin
            r_tick_cnt <= w_tick ? TICK_RELOAD : r_tick_cnt - TICK_W'(1);
            if (w_tick) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// ----------------------------------------------------------------------------
// tb_morse_sequencer
// Directed scenarios followed by a randomized stretch. The reference model
// tracks each letter as a position on a fixed timeline (one load cycle, the
// symbols, the gap) plus a queue of pending codes, and compares led, busy,
// letter_done and in_ready every cycle.
// ----------------------------------------------------------------------------
module tb_morse_sequencer;

  localparam int TD   = 4;
  localparam int GT   = 2;
  localparam int FD   = 4;
  localparam int PW   = 12;
  localparam int LAST = PW * TD + GT * TD;  // timeline position of the final gap cycle

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       abort;
  logic       led;
  logic       busy;
  logic       letter_done;

  int n_checks = 0;
  int n_pass   = 0;

  bit [11:0] pats [8] = '{12'b010111000000, 12'b011101010100, 12'b011101011101,
                          12'b011101010000, 12'b010000000000, 12'b010101110100,
                          12'b011101110100, 12'b010101010000};

  // Reference model state
  int unsigned mq [$];
  bit          m_active;
  int          m_pos;
  int          m_code;
  bit          m_done;

  always #5 clock = ~clock;

  morse_sequencer #(
    .TICK_DIV   (TD),
    .PAT_W      (PW),
    .GAP_TICKS  (GT),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .abort       (abort),
    .led         (led),
    .busy        (busy),
    .letter_done (letter_done)
  );

  function automatic bit exp_led();
    bit [11:0] p;
    if (m_active && m_pos >= 1 && m_pos <= PW * TD) begin
      p = pats[m_code];
      return p[PW - 1 - (m_pos - 1) / TD];
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
  endtask

  // Advances the model across one clock edge given the inputs seen there.
  task automatic model_edge(input bit v, input int code, input bit a, input bit r);
    int pre_size;
    bit do_push;
    pre_size = mq.size();
    if (r || a) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_done   = 1'b0;
    end else begin
      do_push = v && (pre_size < FD);
      m_done  = 1'b0;
      if (!m_active) begin
        if (pre_size > 0) begin
          m_active = 1'b1;
          m_pos    = 0;
          m_code   = int'(mq[0]);
        end
      end else if (m_pos == 0) begin
        void'(mq.pop_front());
        m_pos = 1;
      end else if (m_pos == LAST) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_pos++;
      end
      if (do_push) mq.push_back(code);
    end
  endtask

  // One clock cycle: apply inputs, check in_ready before the edge, check the
  // registered outputs one time unit after it.
  task automatic cycle(input bit v, input int code, input bit a, input bit r);
    in_valid = v;
    in_code  = 3'(code);
    abort    = a;
    reset    = r;
    #1;
    check("in_ready", in_ready, (mq.size() < FD) && !a);
    @(posedge clock);
    model_edge(v, code, a, r);
    #1;
    check("led", led, exp_led());
    check("busy", busy, m_active || (mq.size() > 0));
    check("letter_done", letter_done, m_done);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  initial begin
    in_valid = 1'b0;
    in_code  = 3'd0;
    abort    = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_done   = 1'b0;

    // Reset values in the first cycle after reset
    idle(2);

    // 1. Single letter A
    cycle(1, 0, 0, 0);
    idle(70);

    // 2. Back-to-back E then H
    cycle(1, 4, 0, 0);
    cycle(1, 7, 0, 0);
    idle(130);

    // 3. Full FIFO: B plays while C,D,E,F queue and G is refused; then H is
    //    held on in_valid across the pop cycle of C
    cycle(1, 1, 0, 0);
    idle(3);
    cycle(1, 2, 0, 0);
    cycle(1, 3, 0, 0);
    cycle(1, 4, 0, 0);
    cycle(1, 5, 0, 0);
    cycle(1, 6, 0, 0);
    repeat (60) cycle(1, 7, 0, 0);
    idle(360);

    // 4. Abort during C's 5th symbol with two codes queued
    cycle(1, 2, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    idle(16);
    cycle(0, 0, 1, 0);
    idle(10);

    // 5. Reset during D's gap with in_valid high
    cycle(1, 3, 0, 0);
    idle(52);
    cycle(1, 6, 0, 1);
    cycle(1, 6, 0, 1);
    idle(5);

    // 6. Abort together with a valid G while idle
    cycle(1, 6, 1, 0);
    idle(10);

    // 7. Randomized traffic with occasional abort and reset
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(7) == 0, int'($urandom_range(7)),
            $urandom_range(199) == 0, $urandom_range(499) == 0);
    end
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
